alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Drives the operand/opcode side of the combinational ALU and returns its result to a byte transmitter.
- Collects three received bytes in order (operand A, operand B, opcode) and presents them to the ALU on registered outputs.
- Captures the ALU result and hands it to the TX side with a start/done handshake.
- Sits between the UART RX/TX byte interfaces and the ALU at the top level.

Parameters:
- SIZEDATA, 8, operand/result and byte width.
- SIZEOP, 6, opcode width; taken from RX_DATA[SIZEOP-1:0]; must satisfy SIZEOP <= SIZEDATA.
- TIMEOUT, 1000000, idle cycles allowed between bytes of one frame before the frame is discarded; must be >= 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- RX_DONE  in  1  one-cycle strobe: RX_DATA holds a valid received byte.
- RX_DATA  in  SIZEDATA  received byte.
- ALU_RESULT  in  SIZEDATA  combinational result returned from the ALU.
- TX_DONE  in  1  one-cycle strobe: transmitter has finished the current byte.
- DATOA  out  SIZEDATA  registered operand A to the ALU.
- DATOB  out  SIZEDATA  registered operand B to the ALU.
- OPCODE  out  SIZEOP  registered opcode to the ALU.
- TX_DATA  out  SIZEDATA  registered byte to transmit.
- TX_START  out  1  registered one-cycle request to transmit TX_DATA.
- BUSY  out  1  high in CALC and WAIT_TX.

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (RESET_N).
- Reset (asserted at any time, including mid-frame or mid-transmit):
  - State -> WAIT_A.
  - DATOA, DATOB, OPCODE, TX_DATA = 0; TX_START = 0; timeout counter = 0.
  - No TX_START is issued for an aborted frame.
- States: WAIT_A, WAIT_B, WAIT_OP, CALC, WAIT_TX.
  - WAIT_A: on RX_DONE, DATOA <= RX_DATA, go to WAIT_B. No timeout in this state.
  - WAIT_B: on RX_DONE, DATOB <= RX_DATA, go to WAIT_OP.
  - WAIT_OP: on RX_DONE, OPCODE <= RX_DATA[SIZEOP-1:0] (upper bits discarded), go to CALC.
  - CALC (exactly 1 cycle): TX_DATA <= ALU_RESULT, TX_START <= 1, go to WAIT_TX.
  - WAIT_TX: TX_START is high for exactly the first cycle of the state, then 0. On TX_DONE, go to WAIT_A.
- Latency: third RX_DONE sampled at edge k -> TX_DATA valid and TX_START high after edge k+1 -> TX_START low after edge k+2.
- Operand hold: DATOA/DATOB/OPCODE change only on their capture edges and hold their values through WAIT_TX and into the next frame. BUSY is combinational from state.
- TX_DONE handling: ignored outside WAIT_TX and during the TX_START cycle.
- RX_DONE handling: in CALC and WAIT_TX, bytes are dropped with no buffering; the next frame starts with the first byte after returning to WAIT_A.
- Timeout:
  - The counter clears on entry to WAIT_B and WAIT_OP and increments each cycle there without RX_DONE.
  - After TIMEOUT consecutive cycles without a byte, go to WAIT_A. Captured registers are left unchanged; no TX.
  - RX_DONE in the expiry cycle wins: the byte is captured and no timeout occurs.
  - Counter width is clog2(TIMEOUT)+1; it must not wrap.
- Back-to-back frames: RX_DONE in the first WAIT_A cycle after TX_DONE is accepted.

Test Plan:
- ADD: bytes 0x05, 0x03, 0x20 -> DATOA=0x05, DATOB=0x03, OPCODE=0x20; TX_DATA=0x08; TX_START high for 1 cycle, 2 edges after the third RX_DONE; BUSY=1 until TX_DONE.
- SUB wrap: bytes 0x03, 0x05, 0x22 -> TX_DATA=0xFE. Opcode byte 0xE4 -> OPCODE=0x24; AND of 0xF0, 0x3C -> TX_DATA=0x30.
- Drop while busy: RX_DONE with 0x77 during WAIT_TX, then TX_DONE, then bytes 0x01, 0x01, 0x20 -> TX_DATA=0x02; 0x77 never captured.
- Timeout (TIMEOUT=16): byte 0x09, then 16 idle cycles, then 0x02, 0x04, 0x25 -> DATOA=0x02, TX_DATA=0x06. Repeat with the second byte arriving on idle cycle 16 -> accepted, no timeout.
- Reset mid-op: RESET_N low for 1 cycle during WAIT_TX (and separately during WAIT_OP) -> all outputs 0 immediately, no further TX_START; next full frame processed normally.
- Spurious TX_DONE in WAIT_A/WAIT_B and during the TX_START cycle -> no state change, exactly one TX_START per frame.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Byte-level sequencer between a UART RX/TX pair and a combinational ALU:
// gathers operand A, operand B and opcode, then ships the ALU result back out.
module alu_operand_sequencer #(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                RX_DONE,
    input  logic [SIZEDATA-1:0] RX_DATA,
    input  logic [SIZEDATA-1:0] ALU_RESULT,
    input  logic                TX_DONE,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    output logic [SIZEDATA-1:0] TX_DATA,
    output logic                TX_START,
    output logic                BUSY,
    output logic [2:0]          DBG_STATE
);

    localparam logic [2:0] WAIT_A  = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] CALC    = 3'd3;
    localparam logic [2:0] WAIT_TX = 3'd4;

    localparam int CNTW = $clog2(TIMEOUT) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [2:0]      state;
    logic [CNTW-1:0] cnt;

    assign BUSY      = (state == CALC) || (state == WAIT_TX);
    assign DBG_STATE = state;

    // TX handshake: TX_START is a one-cycle request; TX_DONE completes it, but
    // only once the request cycle has passed (a TX_DONE seen with TX_START high
    // belongs to an earlier byte and is ignored).
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= WAIT_A;
            cnt      <= '0;
            DATOA    <= '0;
            DATOB    <= '0;
            OPCODE   <= '0;
            TX_DATA  <= '0;
            TX_START <= 1'b0;
        end else begin
            TX_START <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (RX_DONE) begin
                        DATOA <= RX_DATA;
                        cnt   <= '0;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (RX_DONE) begin
                        DATOB <= RX_DATA;
                        cnt   <= '0;
                        state <= WAIT_OP;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_OP: begin
                    // A byte in the expiry cycle takes priority over the timeout.
                    if (RX_DONE) begin
                        OPCODE <= RX_DATA[SIZEOP-1:0];
                        cnt    <= '0;
                        state  <= CALC;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                CALC: begin
                    TX_DATA  <= ALU_RESULT;
                    TX_START <= 1'b1;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (TX_DONE && !TX_START) begin
                        state <= WAIT_A;
                    end
                end
                default: begin
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small behavioural ALU
// on ALU_RESULT and a queue of expected transmitted bytes.
module tb_alu_operand_sequencer;

    localparam int W  = 8;
    localparam int OW = 6;
    localparam int TO = 16;

    localparam logic [2:0] S_WAIT_A  = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_OP = 3'd2;
    localparam logic [2:0] S_CALC    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;

    logic          clk;
    logic          rst_n;
    logic          rx_done;
    logic [W-1:0]  rx_data;
    logic [W-1:0]  alu_result;
    logic          tx_done;
    logic [W-1:0]  datoa;
    logic [W-1:0]  datob;
    logic [OW-1:0] opcode;
    logic [W-1:0]  tx_data;
    logic          tx_start;
    logic          busy;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    alu_operand_sequencer #(.SIZEDATA(W), .SIZEOP(OW), .TIMEOUT(TO)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .RX_DONE    (rx_done),
        .RX_DATA    (rx_data),
        .ALU_RESULT (alu_result),
        .TX_DONE    (tx_done),
        .DATOA      (datoa),
        .DATOB      (datob),
        .OPCODE     (opcode),
        .TX_DATA    (tx_data),
        .TX_START   (tx_start),
        .BUSY       (busy),
        .DBG_STATE  (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25
    always_comb begin
        alu_result = '0;
        case (opcode)
            6'h20: alu_result = datoa + datob;
            6'h22: alu_result = datoa - datob;
            6'h24: alu_result = datoa & datob;
            6'h25: alu_result = datoa | datob;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every TX_START must match a queued expected byte
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            if (exp_q.size() == 0) check("tx_start_unexpected", 32'd1, 32'd0);
            else check("tx_data_sb", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic send_byte(input logic [W-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Entered at the negedge right after the opcode capture edge.
    task automatic expect_tx(input logic [W-1:0] exp, input bit spur);
        exp_q.push_back(exp);
        check("calc_state", 32'(dbg_state), 32'(S_CALC));
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_no_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("start_high", 32'(tx_start), 32'd1);
        check("start_data", 32'(tx_data), 32'(exp));
        if (spur) tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("start_low", 32'(tx_start), 32'd0);
        check("wait_tx_state", 32'(dbg_state), 32'(S_WAIT_TX));
        check("wait_tx_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_tx();
        pulse_tx_done();
        check("done_state", 32'(dbg_state), 32'(S_WAIT_A));
        check("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] op, input logic [W-1:0] exp);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check("frame_datoa", 32'(datoa), 32'(a));
        check("frame_datob", 32'(datob), 32'(b));
        check("frame_opcode", 32'(opcode), 32'(op[OW-1:0]));
        expect_tx(exp, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_datoa"}, 32'(datoa), 32'd0);
        check({tag, "_datob"}, 32'(datob), 32'd0);
        check({tag, "_opcode"}, 32'(opcode), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_WAIT_A));
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = '0;
        tx_done = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // ADD, SUB wrap, AND with opcode upper bits discarded
        send_frame(8'h05, 8'h03, 8'h20, 8'h08);
        finish_tx();
        send_frame(8'h03, 8'h05, 8'h22, 8'hFE);
        finish_tx();
        send_frame(8'hF0, 8'h3C, 8'hE4, 8'h30);
        check("hold_opcode", 32'(opcode), 32'h24);
        finish_tx();
        check("hold_datoa_next", 32'(datoa), 32'hF0);

        // Byte during WAIT_TX is dropped
        send_frame(8'h0A, 8'h0B, 8'h20, 8'h15);
        send_byte(8'h77);
        check("drop_state", 32'(dbg_state), 32'(S_WAIT_TX));
        check("drop_datoa", 32'(datoa), 32'h0A);
        finish_tx();
        send_frame(8'h01, 8'h01, 8'h20, 8'h02);
        finish_tx();

        // Spurious TX_DONE in WAIT_A, WAIT_B and in the TX_START cycle
        pulse_tx_done();
        check("spur_a_state", 32'(dbg_state), 32'(S_WAIT_A));
        send_byte(8'h11);
        pulse_tx_done();
        check("spur_b_state", 32'(dbg_state), 32'(S_WAIT_B));
        send_byte(8'h22);
        send_byte(8'h20);
        expect_tx(8'h33, 1'b1);
        finish_tx();

        // Timeout in WAIT_B after 16 idle cycles; registers untouched
        send_byte(8'h09);
        idle(TO);
        check("to_state", 32'(dbg_state), 32'(S_WAIT_A));
        check("to_datoa_kept", 32'(datoa), 32'h09);
        send_frame(8'h02, 8'h04, 8'h25, 8'h06);
        finish_tx();

        // Byte on the expiry cycle wins
        send_byte(8'h0A);
        idle(TO - 1);
        check("edge_state", 32'(dbg_state), 32'(S_WAIT_B));
        send_byte(8'h0C);
        check("edge_accept_state", 32'(dbg_state), 32'(S_WAIT_OP));
        check("edge_datob", 32'(datob), 32'h0C);
        send_byte(8'h20);
        expect_tx(8'h16, 1'b0);
        finish_tx();

        // Timeout in WAIT_OP
        send_byte(8'h01);
        send_byte(8'h02);
        idle(TO);
        check("to_op_state", 32'(dbg_state), 32'(S_WAIT_A));
        check("to_op_opcode_kept", 32'(opcode), 32'h20);

        // Reset during WAIT_TX
        send_frame(8'h07, 8'h01, 8'h20, 8'h08);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait_tx");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_tx_done();
        idle(3);

        // Reset during WAIT_OP, then a clean frame
        send_byte(8'h40);
        send_byte(8'h41);
        check("pre_rst_op_state", 32'(dbg_state), 32'(S_WAIT_OP));
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait_op");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("rst_op_idle_state", 32'(dbg_state), 32'(S_WAIT_A));
        send_frame(8'h02, 8'h03, 8'h20, 8'h05);
        finish_tx();

        idle(3);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
